// File: rtl/jtag_master.sv
// Host-side JTAG sequencer: turns single commands (TAP reset, IR scan, DR scan, idle)
// into TCK/TMS/TDI traffic and parks the target in Run-Test/Idle between commands.
module jtag_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        TCK,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO
);

  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_IR    = 2'b01;
  localparam logic [1:0] CMD_DR    = 2'b10;
  localparam logic [1:0] CMD_IDLE  = 2'b11;

  localparam logic [8:0] RISE_AT = 9'(CLK_DIV - 1);
  localparam logic [8:0] END_AT  = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    PRE   = 3'd2,
    SHIFT = 3'd3,
    POST  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  bit_q, bit_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [1:0]  type_q, type_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic        rdy_q, rdy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_q, rsp_d;

  logic        run_s;
  logic        rise_s;
  logic        end_s;
  logic        scan_s;
  logic [4:0]  bit_nx_s;
  logic [4:0]  pre_last_s;

  assign run_s      = (state_q == INIT) || (state_q == PRE) ||
                      (state_q == SHIFT) || (state_q == POST);
  assign rise_s     = run_s && (cnt_q == RISE_AT);
  assign end_s      = run_s && (cnt_q == END_AT);
  assign scan_s     = (type_q == CMD_IR) || (type_q == CMD_DR);
  assign bit_nx_s   = bit_q + 5'd1;
  assign pre_last_s = (type_q == CMD_IR) ? 5'd3 : 5'd2;

  // Next-state, TCK phase and per-TCK-cycle TMS/TDI selection.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    type_d      = type_q;
    len_d       = len_q;
    data_d      = data_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    cnt_d       = 9'd0;
    tck_d       = 1'b0;

    if (run_s) begin
      cnt_d = end_s ? 9'd0 : cnt_q + 9'd1;
      if (rise_s) begin
        tck_d = 1'b1;
      end else if (end_s) begin
        tck_d = 1'b0;
      end else begin
        tck_d = tck_q;
      end
    end else begin
      cnt_d = 9'd0;
      tck_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          type_d = cmd_type;
          len_d  = cmd_len;
          data_d = cmd_data;
          bit_d  = 5'd0;
          tdi_d  = 1'b0;
          case (cmd_type)
            CMD_RESET: begin
              state_d = INIT;
              tms_d   = 1'b1;
            end
            CMD_IR, CMD_DR: begin
              state_d = PRE;
              tms_d   = 1'b1;
            end
            default: begin
              state_d = SHIFT;
              tms_d   = 1'b0;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      INIT: begin
        if (end_s) begin
          if (bit_q == 5'd5) begin
            state_d = RESP;
          end else begin
            bit_d = bit_nx_s;
            tms_d = (bit_nx_s != 5'd5);
          end
        end else begin
          state_d = INIT;
        end
      end

      PRE: begin
        if (end_s) begin
          if (bit_q == pre_last_s) begin
            state_d = SHIFT;
            bit_d   = 5'd0;
            tms_d   = (len_q == 5'd0);
            tdi_d   = data_q[0];
          end else begin
            bit_d = bit_nx_s;
            tms_d = (type_q == CMD_IR) ? (bit_nx_s < 5'd2) : 1'b0;
            tdi_d = 1'b0;
          end
        end else begin
          state_d = PRE;
        end
      end

      SHIFT: begin
        // First sample of a scan clears the whole word so bits above N read zero.
        if (rise_s && scan_s) begin
          if (bit_q == 5'd0) begin
            rsp_d = 32'd0;
          end else begin
            rsp_d = rsp_q;
          end
          rsp_d[bit_q] = TDO;
        end else begin
          rsp_d = rsp_q;
        end
        if (end_s) begin
          if (bit_q == len_q) begin
            tdi_d = 1'b0;
            bit_d = 5'd0;
            if (scan_s) begin
              state_d = POST;
              tms_d   = 1'b1;
            end else begin
              state_d = RESP;
              tms_d   = 1'b0;
            end
          end else begin
            bit_d = bit_nx_s;
            tms_d = scan_s && (bit_nx_s == len_q);
            tdi_d = scan_s && data_q[bit_nx_s];
          end
        end else begin
          state_d = SHIFT;
        end
      end

      POST: begin
        if (end_s) begin
          if (bit_q == 5'd1) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            bit_d = 5'd1;
            tms_d = 1'b0;
            tdi_d = 1'b0;
          end
        end else begin
          state_d = POST;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = INIT;
        bit_d   = 5'd0;
        tms_d   = 1'b1;
        tdi_d   = 1'b0;
      end
    endcase

    rdy_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any sequence and restarts the TAP reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      bit_q       <= 5'd0;
      cnt_q       <= 9'd0;
      type_q      <= CMD_RESET;
      len_q       <= 5'd0;
      data_q      <= 32'd0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      len_q       <= len_d;
      data_q      <= data_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign busy      = ~rdy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
`timescale 1ns/1ps
// Directed bench for jtag_master with a behavioural TAP target (BYPASS or 32-bit DR)
// driving TDO; each scenario task issues commands and compares the resulting traffic.
module tb_jtag_master;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'b00;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic        TCK, TMS, TDI, TDO;

  int checks = 0;
  int errors = 0;

  jtag_master #(.CLK_DIV(2)) dut (
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_t;

  tap_t        tap_st = SH_DR;
  logic        byp_q = 1'b0;
  logic [31:0] dr_q = 32'd0;
  logic [31:0] upd_q = 32'd0;
  logic [31:0] preload = 32'd0;
  logic        tie1 = 1'b1;
  logic        sel_byp = 1'b1;

  assign TDO = tie1 ? 1'b1 : (sel_byp ? byp_q : dr_q[0]);

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      UPD_IR:  return m ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge TCK) begin
    case (tap_st)
      CAP_DR:  begin byp_q <= 1'b0; dr_q <= preload; end
      SH_DR:   begin byp_q <= TDI;  dr_q <= {TDI, dr_q[31:1]}; end
      UPD_DR:  upd_q <= dr_q;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, TMS);
  end

  logic        tms_log[$];
  logic        tdi_log[$];
  time         rise_t[$];
  time         fall_t[$];
  time         rdy_t = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_last = 32'd0;

  always @(posedge TCK) begin
    tms_log.push_back(TMS);
    tdi_log.push_back(TDI);
    rise_t.push_back($time);
  end
  always @(negedge TCK) fall_t.push_back($time);
  always @(posedge cmd_ready) rdy_t = $time;
  always @(negedge CLK) begin
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_last = rsp_data;
    end
  end

  function automatic logic [63:0] pack(input logic q[$]);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  function automatic time last_fall();
    return (fall_t.size() > 0) ? fall_t[fall_t.size()-1] : 0;
  endfunction

  task automatic clear_logs();
    tms_log.delete();
    tdi_log.delete();
    rise_t.delete();
    fall_t.delete();
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [4:0] l,
                          input logic [31:0] d, output bit ok);
    wait_ready(ok);
    if (ok) begin
      cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
      @(posedge CLK);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({TCK, TMS, TDI, cmd_ready, busy, rsp_valid} !== 6'b010010) begin
      errors++;
      $display("FAIL reset_outputs: got TCK,TMS,TDI,rdy,busy,rsp=%b want 010010",
               {TCK, TMS, TDI, cmd_ready, busy, rsp_valid});
    end
    checks++;
    if (rsp_data !== 32'h0) begin
      errors++; $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data);
    end
  endtask

  task automatic test_init_seq();
    bit ok;
    int bad;
    clear_logs();
    @(negedge CLK);
    reset = 1'b0;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout: cmd_ready never rose"); end
    checks++;
    if (tms_log.size() != 6 || pack(tms_log) !== 64'h1F) begin
      errors++;
      $display("FAIL init_tms: got %0d cycles pattern %h want 6 cycles 1f", tms_log.size(), pack(tms_log));
    end
    checks++;
    if (pack(tdi_log) !== 64'h0) begin
      errors++; $display("FAIL init_tdi: got %h want 0", pack(tdi_log));
    end
    bad = 0;
    if (rise_t.size() != 6 || fall_t.size() != 6) bad++;
    else begin
      for (int i = 0; i < 6; i++) begin
        if (fall_t[i] - rise_t[i] != 20) bad++;
        if (i > 0 && rise_t[i] - rise_t[i-1] != 40) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL init_tck_timing: %0d bad edges, want high 20ns period 40ns", bad);
    end
    checks++;
    if (rdy_t - last_fall() != 10) begin
      errors++; $display("FAIL init_ready_delay: got %0t want 10 after last TCK fall", rdy_t - last_fall());
    end
    checks++;
    if (tap_st !== RTI) begin
      errors++; $display("FAIL init_tap_state: got %s want RTI", tap_st.name());
    end
  endtask

  task automatic test_ir_scan();
    bit ok;
    int n0;
    tie1 = 1'b1;
    clear_logs();
    n0 = rsp_cnt;
    send_cmd(2'b01, 5'd3, 32'h6, ok);
    checks++;
    if (!ok || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ir_accept: ok=%0d rdy=%b busy=%b want 1/0/1", ok, cmd_ready, busy);
    end
    wait_ready(ok);
    checks++;
    if (!ok || tms_log.size() != 10 || pack(tms_log) !== 64'h183) begin
      errors++;
      $display("FAIL ir_tms: got %0d cycles pattern %h want 10 cycles 183", tms_log.size(), pack(tms_log));
    end
    checks++;
    if (pack(tdi_log) !== 64'h060) begin
      errors++; $display("FAIL ir_tdi: got %h want 060", pack(tdi_log));
    end
    checks++;
    if (rsp_cnt - n0 != 1 || rsp_last !== 32'h0000000F) begin
      errors++; $display("FAIL ir_rsp: got %0d pulses data %h want 1 pulse 0000000f", rsp_cnt - n0, rsp_last);
    end
    checks++;
    if (tap_st !== RTI || rdy_t - last_fall() != 10) begin
      errors++; $display("FAIL ir_end: tap %s ready delay %0t want RTI 10", tap_st.name(), rdy_t - last_fall());
    end
  endtask

  task automatic test_dr_32();
    bit ok;
    int n0;
    logic [63:0] exp_tdi;
    tie1 = 1'b0; sel_byp = 1'b0; preload = 32'hDEADBEEF;
    clear_logs();
    n0 = rsp_cnt;
    send_cmd(2'b10, 5'd31, 32'hA5A51234, ok);
    wait_ready(ok);
    exp_tdi = 64'hA5A51234 << 3;
    checks++;
    if (!ok || rsp_cnt - n0 != 1 || rsp_last !== 32'hDEADBEEF) begin
      errors++; $display("FAIL dr32_rsp: got %0d pulses data %h want 1 pulse deadbeef", rsp_cnt - n0, rsp_last);
    end
    checks++;
    if (upd_q !== 32'hA5A51234) begin
      errors++; $display("FAIL dr32_update: got %h want a5a51234", upd_q);
    end
    checks++;
    if (tms_log.size() != 37 || pack(tms_log) !== 64'hC00000001 || pack(tdi_log) !== exp_tdi) begin
      errors++;
      $display("FAIL dr32_pins: %0d cycles tms %h tdi %h want 37 c00000001 %h",
               tms_log.size(), pack(tms_log), pack(tdi_log), exp_tdi);
    end
  endtask

  task automatic test_idle();
    bit ok;
    int n0, bad;
    clear_logs();
    n0 = rsp_cnt;
    send_cmd(2'b11, 5'd9, 32'hFFFFFFFF, ok);
    bad = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      if (busy !== 1'b1) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++; $display("FAIL idle_busy: done=%0d busy-low samples %0d want 1/0", ok, bad);
    end
    checks++;
    if (tms_log.size() != 10 || pack(tms_log) !== 64'h0 || pack(tdi_log) !== 64'h0) begin
      errors++;
      $display("FAIL idle_pins: %0d cycles tms %h tdi %h want 10 0 0", tms_log.size(), pack(tms_log), pack(tdi_log));
    end
    checks++;
    if (rsp_cnt != n0 || rsp_data !== 32'hDEADBEEF || tap_st !== RTI) begin
      errors++;
      $display("FAIL idle_rsp: pulses %0d data %h tap %s want 0 deadbeef RTI", rsp_cnt - n0, rsp_data, tap_st.name());
    end
  endtask

  task automatic test_dr_bypass();
    bit ok;
    int n0;
    tie1 = 1'b0; sel_byp = 1'b1;
    clear_logs();
    n0 = rsp_cnt;
    send_cmd(2'b10, 5'd7, 32'h81, ok);
    cmd_type = 2'b11; cmd_len = 5'd31; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (cmd_ready === 1'b1) begin cmd_valid = 1'b0; ok = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok || rsp_cnt - n0 != 1 || rsp_last !== 32'h00000002) begin
      errors++; $display("FAIL byp_rsp: got %0d pulses data %h want 1 pulse 00000002", rsp_cnt - n0, rsp_last);
    end
    checks++;
    if (tms_log.size() != 13 || pack(tms_log) !== 64'hC01 || pack(tdi_log) !== 64'h408) begin
      errors++;
      $display("FAIL byp_pins: %0d cycles tms %h tdi %h want 13 c01 408", tms_log.size(), pack(tms_log), pack(tdi_log));
    end
    repeat (20) @(negedge CLK);
    checks++;
    if (tms_log.size() != 13 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL busy_ignore: %0d TCK cycles rdy=%b want 13 1", tms_log.size(), cmd_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    int n0;
    tie1 = 1'b0; sel_byp = 1'b0; preload = 32'h12345678;
    clear_logs();
    n0 = rsp_cnt;
    send_cmd(2'b10, 5'd31, 32'hFFFFFFFF, ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (tms_log.size() >= 9) begin ok = 1'b1; break; end
    end
    reset = 1'b1;
    #1;
    checks++;
    if (!ok || {TCK, TMS, TDI, cmd_ready, busy, rsp_valid} !== 6'b010010 || rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_outputs: reached=%0d pins %b data %h want 1 010010 0",
               ok, {TCK, TMS, TDI, cmd_ready, busy, rsp_valid}, rsp_data);
    end
    repeat (3) @(negedge CLK);
    clear_logs();
    reset = 1'b0;
    wait_ready(ok);
    checks++;
    if (!ok || tms_log.size() != 6 || pack(tms_log) !== 64'h1F || tap_st !== RTI) begin
      errors++;
      $display("FAIL abort_reinit: %0d cycles tms %h tap %s want 6 1f RTI", tms_log.size(), pack(tms_log), tap_st.name());
    end
    checks++;
    if (rsp_cnt != n0) begin
      errors++; $display("FAIL abort_no_rsp: got %0d pulses want 0", rsp_cnt - n0);
    end
  endtask

  initial begin
    test_reset();
    test_init_seq();
    test_ir_scan();
    test_dr_32();
    test_idle();
    test_dr_bypass();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, giving the TCK half-period in CLK cycles (legal range 1..255).
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 SHALL have port cmd_ready, output, 1 bit: a command is accepted when cmd_valid and cmd_ready are both 1 on the same CLK edge.
REQ-006 SHALL have port cmd_type, input, 2 bits: 00 = TAP reset, 01 = IR scan, 10 = DR scan, 11 = idle.
REQ-007 SHALL have port cmd_len, input, 5 bits: scan length or idle count, equal to cmd_len+1 (range 1..32).
REQ-008 SHALL have port cmd_data, input, 32 bits: TDI data, shifted out LSB first.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-CLK pulse marking the end of a scan.
REQ-010 SHALL have port rsp_data, output, 32 bits: captured TDO bits, LSB first.
REQ-011 SHALL have port busy, output, 1 bit: high whenever a sequence is in progress.
REQ-012 SHALL have ports TCK, TMS and TDI, each output, 1 bit, driving the target TAP.
REQ-013 SHALL have port TDO, input, 1 bit, driven by the target TAP.

Function
REQ-014 SHALL time every TCK cycle over 2*CLK_DIV CLK cycles: TCK low for the first CLK_DIV cycles, high for the second CLK_DIV cycles; TCK is low while idle.
REQ-015 SHALL update TMS and TDI only at the start of a TCK cycle, coincident with TCK going (or staying) low.
REQ-016 SHALL sample TDO on the CLK edge where TCK rises.
REQ-017 SHALL implement host FSM states INIT, IDLE, PRE, SHIFT, POST and RESP; the controller is always parked in Run-Test/Idle between commands.
REQ-018 SHALL hold cmd_ready = 1 only in IDLE, and SHALL drive busy = ~cmd_ready.
REQ-019 SHALL latch cmd_type, cmd_len and cmd_data on acceptance, and SHALL deassert cmd_ready on the next CLK cycle.
REQ-020 SHALL, for a TAP reset command, drive TMS = 1,1,1,1,1,0 on 6 TCK cycles.
REQ-021 SHALL, for an IR scan, drive PRE = TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR), then the SHIFT phase, then POST.
REQ-022 SHALL, for a DR scan, drive PRE = TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR), then the SHIFT phase, then POST.
REQ-023 SHALL, in the SHIFT phase, run N = cmd_len+1 TCK cycles with TDI = cmd_data[i] on cycle i, TMS = 0 on cycles 0..N-2, and TMS = 1 on cycle N-1 (Exit1).
REQ-024 SHALL, in POST, drive TMS = 1 then TMS = 0 (Update, then Run-Test/Idle).
REQ-025 SHALL store the TDO sampled on shift cycle i into rsp_data[i], and SHALL zero rsp_data[31:N].
REQ-026 SHALL, after the last POST TCK cycle of a scan, return TCK low, pulse rsp_valid for one CLK cycle (RESP), and assert cmd_ready on the following cycle.
REQ-027 SHALL, for an idle command, run cmd_len+1 TCK cycles with TMS = 0 and produce no rsp_valid.
REQ-028 SHALL drive TDI = 0 on every non-shift TCK cycle.
REQ-029 SHALL hold rsp_data stable until the next scan's first TDO sample.
REQ-030 SHALL ignore cmd_valid while busy, with no queuing.

Reset
REQ-031 SHALL, while reset = 1, force TCK = 0, TMS = 1, TDI = 0, cmd_ready = 0, busy = 1, rsp_valid = 0, rsp_data = 0, with the FSM in INIT.
REQ-032 SHALL, after reset deasserts, perform the REQ-020 TAP reset sequence (INIT) before entering IDLE, because the target state is unknown.
REQ-033 SHALL, on reset asserted mid-sequence (including mid-SHIFT), abort immediately, emit no rsp_valid, and discard the latched command.

Verification
REQ-034 SHALL be verified by: CLK_DIV=2, release reset -> 6 TCK pulses each 4 CLK long with TMS 1,1,1,1,1,0 -> cmd_ready=1 one CLK after the last TCK pulse completes.
REQ-035 SHALL be verified by: IR scan, cmd_len=3, cmd_data=0x6, TDO tied 1 -> TMS 1,1,0,0,0,0,0,1,1,0; TDI on shift cycles 0,1,1,0; rsp_valid pulse with rsp_data=0x0000000F.
REQ-036 SHALL be verified by: DR scan, cmd_len=7, cmd_data=0x81, bench TAP model in BYPASS (1-bit register capturing 0) -> rsp_data=0x00000002.
REQ-037 SHALL be verified by: DR scan, cmd_len=31, cmd_data=0xA5A51234, TDO looped from a 32-bit model register preloaded with 0xDEADBEEF -> rsp_data=0xDEADBEEF, and the model register equals 0xA5A51234 after Update-DR.
REQ-038 SHALL be verified by: idle command, cmd_len=9 -> 10 TCK cycles with TMS=0, busy=1 throughout, no rsp_valid.
REQ-039 SHALL be verified by: reset asserted during shift cycle 5 of a 32-bit scan -> TCK=0 and TMS=1 immediately, no rsp_valid, then the 6-TCK reset sequence -> IDLE.
